// File: rtl/fir_stream_pkg.sv
// Shared types and helpers for the FIR sample stream blocks.
package fir_stream_pkg;

    localparam int SAMPLE_WIDTH    = 16;
    localparam int DROP_CNT_WIDTH  = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [DROP_CNT_WIDTH-1:0]      drop_cnt_t;

    // Address width for a buffer of the given depth (never below one bit).
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage : fir_stream_pkg

// File: rtl/fir_fifo_ram.sv
// Sample storage: one synchronous write port, one asynchronous read port.
// The array is deliberately left unreset; validity is tracked by the owner.
module fir_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the incoming sample on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so the FIFO can fall through.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule : fir_fifo_ram

// File: rtl/fir_dout_fifo.sv
// Output buffer behind the polyphase decimator: push-only input stream,
// valid/ready output, sticky overflow flag and saturating drop counter.
//
// Output handshake: dout_valid is high whenever a sample is held and does
// not depend on dout_ready; dout stays stable while dout_valid is high and
// dout_ready is low. A transfer happens on every clk edge where both
// dout_valid and dout_ready are high. The input side has no ready: a
// sample offered while full and not draining is dropped and counted.
module fir_dout_fifo
    import fir_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_valid,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          drop_count,
    input  logic                          clr_stats
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  full;
    logic                  not_empty;

    fir_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    // Push/pop/drop decisions; a pop frees a slot for a push in the same cycle.
    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == FULL_LVL);
        pop       = not_empty && dout_ready;
        push      = din_valid && (!full || pop);
        drop      = din_valid && full && !pop;
    end

    // Pointers and occupancy; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Drop statistics; a drop in the clearing cycle is counted after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_stats) begin
            overflow   <= drop;
            drop_count <= drop ? CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

    // Output view derived from registered occupancy; zeroed when empty.
    always_comb begin
        dout_valid = not_empty;
        dout       = not_empty ? head_data : '0;
        level      = level_q;
    end

endmodule : fir_dout_fifo

// File: doc/fir_dout_fifo.md
Name: fir_dout_fifo

Overview:
- Output buffer directly downstream of polyphase_fir_decimator_63tap.
- Accepts the decimator's push-only stream (din_valid/din, no backpressure) and presents it to a backpressured consumer over a valid/ready interface.
- Absorbs consumer stalls up to DEPTH samples.
- Counts and flags samples dropped on overflow, so sample loss is visible to software and to the bench.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement, matches decimator dout)
DEPTH, 16, buffer entries; power of two, >= 2
CNT_WIDTH, 16, width of drop counter

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
din_valid  in  1  input sample strobe from decimator dout_valid
din  in  DATA_WIDTH  signed sample from decimator dout
dout_valid  out  1  head sample available
dout_ready  in  1  consumer accepts head this cycle
dout  out  DATA_WIDTH  head sample; 0 when dout_valid=0
level  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow  out  1  sticky: at least one sample dropped since reset/clear
drop_count  out  CNT_WIDTH  dropped samples, saturating
clr_stats  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async assert, sync-to-clk release by the system):
  - wr_ptr = rd_ptr = 0, level = 0, dout_valid = 0, dout = 0, overflow = 0, drop_count = 0.
  - Storage contents are not reset.
- Push = din_valid && (level<DEPTH || pop).
- Pop = dout_valid && dout_ready.
- Both evaluated on the same clk edge.
- Latency: a sample pushed at edge N is visible on dout with dout_valid=1 after edge N. This is one cycle, with no combinational din->dout path, even when empty.
- First-word-fall-through: dout = mem[rd_ptr] whenever level>0; dout_valid = (level!=0), derived from registered level.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level update:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- Full (level==DEPTH) with simultaneous pop and din_valid: push accepted, level stays DEPTH, no drop.
- Full, din_valid, no pop: sample discarded; stored data unchanged; overflow <= 1; drop_count <= drop_count+1, saturating at 2^CNT_WIDTH-1.
- Empty with dout_ready=1: no effect. Pop is impossible because dout_valid=0.
- clr_stats=1: overflow <= 0, drop_count <= 0. If a drop occurs the same cycle, the drop is counted after the clear: overflow=1, drop_count=1.
- clr_stats does not affect data path or level.
- Reset mid-operation discards all buffered samples immediately. dout_valid falls asynchronously with rst.
- din is never sign-modified or truncated; data stored verbatim.
- Consumer may hold dout_ready high continuously. Sustained throughput is 1 sample/clk.

Decomposition:
- Shared package fir_stream_pkg:
  - SAMPLE_WIDTH = 16
  - typedef logic signed [SAMPLE_WIDTH-1:0] sample_t
  - function clog2-based addr width helper
  - typedef for drop counter
- Sub-module fir_fifo_ram:
  - DEPTH x DATA_WIDTH register array
  - One synchronous write port (we, waddr, wdata)
  - One asynchronous read port (raddr, rdata)
  - No reset on storage
- Top holds pointers, level, flags and counter.

Test Plan:
- Basic pass-through: push 100, -200, 32767, -32768 on consecutive clks with dout_ready=1 -> same values appear in order, each one cycle after push. level never exceeds 1. drop_count=0.
- Fill/drain: dout_ready=0, push 16 samples 1..16 -> level=16, dout=1, dout_valid=1. Then dout_ready=1 -> outputs 1..16 on 16 consecutive cycles, then dout_valid=0, dout=0, level=0.
- Overflow: full with 1..16, dout_ready=0, push 3 more (17,18,19) -> overflow=1, drop_count=3. Drain yields exactly 1..16.
- Full with simultaneous push/pop: full with 1..16, dout_ready=1 and push 17 same cycle -> no drop, level=16. Drain yields 2..17.
- Wrap and stats: run 40 samples through at varying dout_ready duty (pointers wrap twice) -> output equals input sequence. Pulse clr_stats coincident with a drop -> overflow=1, drop_count=1.
- Reset mid-operation: level=7, assert rst for 2 clks -> dout_valid=0, level=0, drop_count=0 immediately. Next push 42 -> dout=42 one cycle later.
